viterbi_decoder: RTL and testbench

VITERBI_DECODER -- requirements
Module: viterbi_decoder

---
 rtl/viterbi_pkg.sv | 21 ++
 rtl/viterbi_acs.sv | 26 ++
 rtl/viterbi_decoder.sv | 122 ++++++++++++
 tb/tb_viterbi_decoder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the rate-1/2 hard-decision Viterbi decoder.
// Defaults: K=3 (4 trellis states), G0=111, G1=101, 32-symbol decision depth.
package viterbi_pkg;

    localparam int          VIT_K        = 3;
    localparam logic [2:0]  VIT_G0       = 3'b111;
    localparam logic [2:0]  VIT_G1       = 3'b101;
    localparam int          VIT_TBLEN    = 32;
    localparam int          VIT_METRIC_W = 8;
    localparam int          VIT_NS       = 1 << (VIT_K - 1);

    typedef logic [VIT_METRIC_W-1:0] metric_t;

    // Largest value representable in w bits, clamping v to it.
    function automatic int sat_metric(input int v, input int w);
        int max_v;
        max_v = (1 << w) - 1;
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; purely combinational, no backpressure.
// Ties keep predecessor 0 (the lower state index); sums saturate at all-ones.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int W = VIT_METRIC_W
) (
    input  logic [W-1:0] m0_i,
    input  logic [W-1:0] m1_i,
    input  logic [1:0]   bm0_i,
    input  logic [1:0]   bm1_i,
    output logic [W-1:0] m_o,
    output logic         dec_o
);

    logic [W:0] sum0;
    logic [W:0] sum1;
    logic [W:0] sel;

    assign sum0  = {1'b0, m0_i} + (W+1)'(bm0_i);
    assign sum1  = {1'b0, m1_i} + (W+1)'(bm1_i);
    assign dec_o = (sum1 < sum0);
    assign sel   = dec_o ? sum1 : sum0;
    assign m_o   = sel[W] ? {W{1'b1}} : sel[W-1:0];

endmodule

// File: rtl/viterbi_decoder.sv
// Register-exchange Viterbi decoder; decoded bit for symbol n registered on the edge accepting n+TBLEN.
// No backpressure: every valid cycle advances the trellis, invalid cycles freeze all state.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int             K        = VIT_K,
    parameter logic [K-1:0]   G0       = VIT_G0,
    parameter logic [K-1:0]   G1       = VIT_G1,
    parameter int             TBLEN    = VIT_TBLEN,
    parameter int             METRIC_W = VIT_METRIC_W
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       d_in_valid,
    input  logic [1:0] d_in,
    output logic       d_out_valid,
    output logic       d_out
);

    localparam int NS = 1 << (K - 1);
    localparam int SW = K - 1;
    localparam int CW = $clog2(TBLEN + 1);
    localparam logic [METRIC_W-1:0] M_INIT = METRIC_W'(sat_metric(2 * TBLEN, METRIC_W));
    localparam logic [CW-1:0]       CNT_MAX = CW'(TBLEN);

    logic [METRIC_W-1:0] metric_q [NS];
    logic [METRIC_W-1:0] metric_d [NS];
    logic [METRIC_W-1:0] acs_m    [NS];
    logic [NS-1:0]       acs_dec;
    logic [TBLEN-1:0]    path_q   [NS];
    logic [TBLEN-1:0]    path_d   [NS];
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                d_out_valid_q, d_out_q;
    logic [METRIC_W-1:0] min_new;
    logic [METRIC_W-1:0] best_m;
    logic [SW-1:0]       best_idx;

    // r = {input bit, predecessor state}; returns Hamming distance to the received symbol.
    function automatic logic [1:0] branch_metric(input logic [K-1:0] r, input logic [1:0] sym);
        logic [1:0] exp_sym;
        logic [1:0] diff;
        exp_sym = {^(r & G1), ^(r & G0)};
        diff    = exp_sym ^ sym;
        return {1'b0, diff[0]} + {1'b0, diff[1]};
    endfunction

    for (genvar s = 0; s < NS; s++) begin : g_state
        localparam logic [SW-1:0] P0 = SW'((s << 1) % NS);
        localparam logic [SW-1:0] P1 = P0 | SW'(1);
        localparam logic          U  = 1'((s >> (SW - 1)) & 1);

        logic [1:0] bm0, bm1;

        assign bm0 = branch_metric({U, P0}, d_in);
        assign bm1 = branch_metric({U, P1}, d_in);

        viterbi_acs #(.W(METRIC_W)) u_acs (
            .m0_i  (metric_q[P0]),
            .m1_i  (metric_q[P1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .m_o   (acs_m[s]),
            .dec_o (acs_dec[s])
        );

        assign path_d[s] = acs_dec[s] ? {path_q[P1][TBLEN-2:0], U}
                                      : {path_q[P0][TBLEN-2:0], U};
        assign metric_d[s] = acs_m[s] - min_new;
    end

    always_comb begin
        min_new = acs_m[0];
        for (int s = 1; s < NS; s++) begin
            if (acs_m[s] < min_new) begin
                min_new = acs_m[s];
            end
        end
    end

    // Output decision uses the pre-update survivors, whose MSB is exactly TBLEN symbols old.
    always_comb begin
        best_m   = metric_q[0];
        best_idx = '0;
        for (int s = 1; s < NS; s++) begin
            if (metric_q[s] < best_m) begin
                best_m   = metric_q[s];
                best_idx = SW'(s);
            end
        end
    end

    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (RSTn) begin
            for (int s = 0; s < NS; s++) begin
                metric_q[s] <= (s == 0) ? '0 : M_INIT;
                path_q[s]   <= '0;
            end
            cnt_q         <= '0;
            d_out_valid_q <= 1'b0;
            d_out_q       <= 1'b0;
        end else begin
            d_out_valid_q <= 1'b0;
            if (d_in_valid) begin
                for (int s = 0; s < NS; s++) begin
                    metric_q[s] <= metric_d[s];
                    path_q[s]   <= path_d[s];
                end
                cnt_q <= cnt_d;
                if (cnt_q == CNT_MAX) begin
                    d_out_valid_q <= 1'b1;
                    d_out_q       <= path_q[best_idx][TBLEN-1];
                end
            end
        end
    end

    assign d_out_valid = d_out_valid_q;
    assign d_out       = d_out_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboarded bench for viterbi_decoder: a reference encoder feeds the DUT and
// queues each message bit, outputs are popped and compared as they appear.
module tb_viterbi_decoder;

    logic       clk = 1'b0;
    logic       RSTn;
    logic       d_in_valid;
    logic [1:0] d_in;
    logic       d_out_valid;
    logic       d_out;

    viterbi_decoder dut (
        .clk         (clk),
        .RSTn        (RSTn),
        .d_in_valid  (d_in_valid),
        .d_in        (d_in),
        .d_out_valid (d_out_valid),
        .d_out       (d_out)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         accepted;
    int         n_out;
    logic [1:0] enc_st;
    logic       exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // K=3 encoder, G0=111, G1=101, state = {previous bit, bit before}.
    task automatic enc(input logic u, output logic [1:0] sym);
        sym[0] = u ^ enc_st[1] ^ enc_st[0];
        sym[1] = u ^ enc_st[0];
        enc_st = {u, enc_st[1]};
    endtask

    task automatic cycle(input logic vld, input logic [1:0] sym);
        d_in_valid = vld;
        d_in       = sym;
        @(posedge clk);
        #1;
        if (vld) accepted++;
        if (!vld) chk("gap_vld", 32'(d_out_valid), 0);
        if (d_out_valid) begin
            n_out++;
            if (n_out == 1) chk("first_latency", accepted, 33);
            if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
            else chk($sformatf("d_out[%0d]", n_out - 1), 32'(d_out), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic do_reset(input int cycles);
        RSTn       = 1'b1;
        d_in_valid = 1'b1;
        d_in       = 2'b11;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            chk("rst_vld", 32'(d_out_valid), 0);
            chk("rst_dout", 32'(d_out), 0);
        end
        RSTn       = 1'b0;
        d_in_valid = 1'b0;
        exp_q.delete();
        enc_st   = 2'b00;
        accepted = 0;
        n_out    = 0;
    endtask

    task automatic run_stream(input string name, input logic [511:0] msg,
                              input bit flips, input bit gaps);
        logic [1:0] sym;
        logic       u;
        enc_st   = 2'b00;
        accepted = 0;
        n_out    = 0;
        for (int i = 0; i < 544; i++) begin
            u = (i < 512) ? msg[i] : 1'b0;
            enc(u, sym);
            if (flips && (i % 20) == 19) sym[i % 2] = ~sym[i % 2];
            if (i < 512) exp_q.push_back(u);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) cycle(1'b0, 2'($urandom));
            end
            cycle(1'b1, sym);
        end
        repeat (3) cycle(1'b0, 2'b00);
        chk({name, "_n_out"}, n_out, 512);
        chk({name, "_q_left"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [511:0] msg;
        logic [1:0]   sym;
        RSTn       = 1'b1;
        d_in_valid = 1'b0;
        d_in       = 2'b00;

        // Reset held with valid symbols present: nothing may come out.
        do_reset(4);

        run_stream("zeros", '0, 1'b0, 1'b0);

        do_reset(1);
        run_stream("ones", '1, 1'b0, 1'b0);

        for (int w = 0; w < 16; w++) msg[w*32 +: 32] = $urandom();
        do_reset(1);
        run_stream("rand_err", msg, 1'b1, 1'b0);

        do_reset(1);
        run_stream("rand_gaps", msg, 1'b1, 1'b1);

        // 100 symbols of an old message, then a one-cycle reset mid-stream.
        do_reset(1);
        for (int w = 0; w < 16; w++) msg[w*32 +: 32] = $urandom();
        for (int i = 0; i < 100; i++) begin
            enc(msg[i], sym);
            if (i < 68) exp_q.push_back(msg[i]);
            cycle(1'b1, sym);
        end
        chk("pre_rst_n_out", n_out, 68);
        do_reset(1);
        for (int w = 0; w < 16; w++) msg[w*32 +: 32] = $urandom();
        run_stream("after_rst", msg, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
